// File: rtl/sha256_msg_schedule_pkg.sv
// Shared SHA-256 message-schedule definitions: widths, FSM encoding,
// the small-sigma rotate/shift amounts and a rotate-right helper.
package sha256_msg_schedule_pkg;

    localparam int SCHED_WORD_W = 32;
    localparam int SCHED_ROUNDS = 64;
    localparam int SCHED_WIN    = 16;

    // Small sigma amounts: s0 = ROTR7 ^ ROTR18 ^ SHR3, s1 = ROTR17 ^ ROTR19 ^ SHR10
    localparam int S0_ROT_A = 7;
    localparam int S0_ROT_B = 18;
    localparam int S0_SHR_C = 3;
    localparam int S1_ROT_A = 17;
    localparam int S1_ROT_B = 19;
    localparam int S1_SHR_C = 10;

    typedef enum logic [0:0] {
        ST_LOAD   = 1'b0,
        ST_STREAM = 1'b1
    } sched_state_e;

    // Rotate a 32-bit word right by n places
    function automatic logic [SCHED_WORD_W-1:0] rotr32(input logic [SCHED_WORD_W-1:0] x,
                                                       input int unsigned n);
        logic [2*SCHED_WORD_W-1:0] w_dbl;
        w_dbl  = {x, x} >> n;
        rotr32 = w_dbl[SCHED_WORD_W-1:0];
    endfunction

endpackage

// File: rtl/sha256_sched_sigma.sv
// Combinational SHA-256 sigma: ROTR(A) ^ ROTR(B) ^ (SHR or ROTR)(C).
// The third term is a logical shift for the schedule sigmas and a rotate
// for the round-function sigmas, chosen by C_IS_SHR.
module sha256_sched_sigma
    import sha256_msg_schedule_pkg::*;
#(
    parameter int WORD_W   = SCHED_WORD_W,
    parameter int ROT_A    = S0_ROT_A,
    parameter int ROT_B    = S0_ROT_B,
    parameter int ROT_C    = S0_SHR_C,
    parameter bit C_IS_SHR = 1'b1
) (
    input  logic [WORD_W-1:0] i_x,
    output logic [WORD_W-1:0] o_y
);

    logic [WORD_W-1:0] w_term_c;

    if (C_IS_SHR) begin : g_shr
        assign w_term_c = i_x >> ROT_C;
    end else begin : g_rot
        assign w_term_c = rotr32(i_x, ROT_C);
    end

    assign o_y = rotr32(i_x, ROT_A) ^ rotr32(i_x, ROT_B) ^ w_term_c;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander. Accepts 16 big-endian words of one
// block, then streams W[0..63] one word per downstream handshake. The
// 16-word window shifts down on each accepted output and appends the next
// expanded word, so win[0] is always the word being presented.
module sha256_msg_schedule
    import sha256_msg_schedule_pkg::*;
#(
    parameter int WORD_W = SCHED_WORD_W,
    parameter int ROUNDS = SCHED_ROUNDS,
    parameter int WIN    = SCHED_WIN
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_word,
    output logic [5:0]        w_index,
    output logic              w_last
);

    localparam logic [5:0] CNT_LOAD_LAST   = 6'(WIN - 1);
    localparam logic [5:0] CNT_STREAM_LAST = 6'(ROUNDS - 1);

    sched_state_e      r_state;
    logic [5:0]        r_cnt;
    logic [WORD_W-1:0] r_win [WIN];

    logic [WORD_W-1:0] w_s0;
    logic [WORD_W-1:0] w_s1;
    logic [WORD_W-1:0] w_next;

    sha256_sched_sigma #(
        .WORD_W  (WORD_W),
        .ROT_A   (S0_ROT_A),
        .ROT_B   (S0_ROT_B),
        .ROT_C   (S0_SHR_C),
        .C_IS_SHR(1'b1)
    ) u_sigma0 (
        .i_x(r_win[1]),
        .o_y(w_s0)
    );

    sha256_sched_sigma #(
        .WORD_W  (WORD_W),
        .ROT_A   (S1_ROT_A),
        .ROT_B   (S1_ROT_B),
        .ROT_C   (S1_SHR_C),
        .C_IS_SHR(1'b1)
    ) u_sigma1 (
        .i_x(r_win[14]),
        .o_y(w_s1)
    );

    // Next schedule word W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], carry dropped
    assign w_next = w_s1 + r_win[9] + w_s0 + r_win[0];

    // FSM, shared load/round counter and shift window; flush outranks any handshake
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_state <= ST_LOAD;
            r_cnt   <= 6'd0;
            for (int i = 0; i < WIN; i++) begin
                r_win[i] <= '0;
            end
        end else if (flush) begin
            r_state <= ST_LOAD;
            r_cnt   <= 6'd0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (in_valid) begin
                        r_win[r_cnt[3:0]] <= in_word;
                        if (r_cnt == CNT_LOAD_LAST) begin
                            r_cnt   <= 6'd0;
                            r_state <= ST_STREAM;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                ST_STREAM: begin
                    if (w_ready) begin
                        for (int i = 0; i < WIN - 1; i++) begin
                            r_win[i] <= r_win[i+1];
                        end
                        r_win[WIN-1] <= w_next;
                        if (r_cnt == CNT_STREAM_LAST) begin
                            r_cnt   <= 6'd0;
                            r_state <= ST_LOAD;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                    r_cnt   <= 6'd0;
                end
            endcase
        end
    end

    assign in_ready = (r_state == ST_LOAD);
    assign w_valid  = (r_state == ST_STREAM);
    assign w_word   = r_win[0];
    assign w_index  = r_cnt;
    assign w_last   = (r_state == ST_STREAM) && (r_cnt == CNT_STREAM_LAST);

endmodule
